// File: rtl/mod_down_count_pkg.sv
// Shared definitions for the modulo counters: state encoding and default bounds.
package mod_count_pkg;

   typedef enum logic {
      ST_COUNT = 1'b0,
      ST_HALT  = 1'b1
   } state_t;

   // Default bounds, shared with the 5-to-15 up-counter.
   localparam int CNT_HI_DEF = 15;
   localparam int CNT_LO_DEF = 5;

endpackage

// File: rtl/mod_down_count_if.sv
// Control/status bundle for mod_down_count.
// Optional macro WRAP_CNT_EN adds the saturating wrap counter output.
interface mod_down_count_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             oneshot;
   logic [WIDTH-1:0] out;
   logic             tc;
   logic             done;
`ifdef WRAP_CNT_EN
   logic [7:0]       wrap_cnt;

   modport master (output en, load, load_val, oneshot, input out, tc, done, wrap_cnt);
   modport slave  (input en, load, load_val, oneshot, output out, tc, done, wrap_cnt);
`else
   modport master (output en, load, load_val, oneshot, input out, tc, done);
   modport slave  (input en, load, load_val, oneshot, output out, tc, done);
`endif
endinterface

// File: rtl/mod_down_count_clamp.sv
// Combinational clamp: values outside [LO, HI] are mapped to HI.
import mod_count_pkg::*;

module mod_count_clamp #(
   parameter int WIDTH = 4,
   parameter int HI    = CNT_HI_DEF,
   parameter int LO    = CNT_LO_DEF
) (
   input  logic [WIDTH-1:0] v,
   output logic [WIDTH-1:0] y
);
   localparam logic [WIDTH-1:0] HI_V = WIDTH'(HI);
   localparam logic [WIDTH-1:0] LO_V = WIDTH'(LO);

   // Out-of-range values map to the reload value HI.
   always_comb begin
      y = v;
      if ((v > HI_V) || (v < LO_V)) begin
         y = HI_V;
      end
   end
endmodule

// File: rtl/mod_down_count.sv
// Modulo down-counter HI..LO with enable, clamped parallel load, terminal-count
// pulse and one-shot halt. Optional macro WRAP_CNT_EN adds a saturating count
// of terminal-count pulses (wrap_cnt).
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_COUNT | counting down on en; wraps to HI or halts at LO
//   ST_HALT  | one-shot finished, out parked at LO, done high, waits load
import mod_count_pkg::*;

module mod_down_count #(
   parameter int WIDTH = 4,
   parameter int HI    = CNT_HI_DEF,
   parameter int LO    = CNT_LO_DEF
) (
   input  logic          clk,
   input  logic          rst,
   mod_down_count_if.slave bus
);
   localparam logic [WIDTH-1:0] HI_V = WIDTH'(HI);
   localparam logic [WIDTH-1:0] LO_V = WIDTH'(LO);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             tc_q, tc_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] load_clamped;
   logic [WIDTH-1:0] out_clamped;
   logic             out_illegal;

   mod_count_clamp #(.WIDTH(WIDTH), .HI(HI), .LO(LO)) u_clamp_load (
      .v (bus.load_val),
      .y (load_clamped)
   );

   // Second clamp detects an out value that escaped [LO, HI].
   mod_count_clamp #(.WIDTH(WIDTH), .HI(HI), .LO(LO)) u_clamp_out (
      .v (out_q),
      .y (out_clamped)
   );

   assign out_illegal = (out_clamped != out_q);

   // State and output registers; reset parks the counter at HI.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_COUNT;
         out_q   <= HI_V;
         tc_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         tc_q    <= tc_d;
         done_q  <= done_d;
      end
   end

   // Next-state and next-output logic; load always beats the terminal step.
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      tc_d    = 1'b0;
      done_d  = done_q;
      case (state_q)
         ST_COUNT: begin
            done_d = 1'b0;
            if (bus.load) begin
               out_d = load_clamped;
            end else if (bus.en) begin
               if (out_illegal) begin
                  out_d = HI_V;
               end else if (out_q > LO_V) begin
                  out_d = out_q - 1'b1;
               end else if (!bus.oneshot) begin
                  out_d = HI_V;
                  tc_d  = 1'b1;
               end else begin
                  tc_d    = 1'b1;
                  done_d  = 1'b1;
                  state_d = ST_HALT;
               end
            end
         end
         ST_HALT: begin
            done_d = 1'b1;
            if (bus.load) begin
               out_d   = load_clamped;
               done_d  = 1'b0;
               state_d = ST_COUNT;
            end
         end
         default: begin
            state_d = ST_COUNT;
            out_d   = HI_V;
            done_d  = 1'b0;
         end
      endcase
   end

   assign bus.out  = out_q;
   assign bus.tc   = tc_q;
   assign bus.done = done_q;

`ifdef WRAP_CNT_EN
   logic [7:0] wrap_q;

   // Saturating count of terminal-count pulses, cleared by any load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrap_q <= 8'd0;
      end else if (bus.load) begin
         wrap_q <= 8'd0;
      end else if (tc_d && (wrap_q != 8'hFF)) begin
         wrap_q <= wrap_q + 8'd1;
      end
   end

   assign bus.wrap_cnt = wrap_q;
`endif

endmodule

// File: doc/mod_down_count.md
Name: mod_down_count

Overview:
Synchronous modulo down-counter, the descending counterpart of the team's 5-to-15 up-counter. Counts from HI down to LO, then wraps to HI in continuous mode or halts in one-shot mode. Has an enable, a parallel load and a terminal-count pulse, so it can serve as a reloadable timer or period generator beside the up-counter.

Parameters:
WIDTH, 4, counter width in bits
HI, 15, upper bound; reload value after wrap and after reset
LO, 5, lower bound; terminal value. Legal only when LO < HI <= 2^WIDTH-1.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
en  input  1  count enable; one decrement per clock while high
load  input  1  synchronous parallel load; has priority over en
load_val  input  WIDTH  value captured on load (clamped, see Behaviour)
oneshot  input  1  0 = continuous wrap; 1 = halt at LO
out  output  WIDTH  current count, registered
tc  output  1  one-cycle registered terminal-count pulse
done  output  1  high while halted in one-shot mode

Behaviour:
- Reset (asynchronous, any cycle including mid-count): out=HI, tc=0, done=0, state=COUNT.
- FSM has two states, COUNT and HALT.
- COUNT, priority order per rising edge:
  - load=1: out <= clamp(load_val); tc <= 0; stay COUNT. clamp(v) = HI when v > HI or v < LO, otherwise v.
  - en=1, out > LO: out <= out-1; tc <= 0.
  - en=1, out == LO, oneshot=0: out <= HI; tc <= 1 (tc high in the same cycle out first shows HI).
  - en=1, out == LO, oneshot=1: out holds LO; tc <= 1; done <= 1; state <= HALT.
  - en=0: out holds; tc <= 0.
- HALT:
  - out holds LO; done=1; tc=0; en is ignored.
  - load=1: out <= clamp(load_val); done <= 0; state <= COUNT.
- oneshot is sampled only on the LO step. Changing it mid-count takes effect at the next terminal step.
- Simultaneous load and terminal step: load wins; no tc, no halt.
- Latency: every change on out, tc or done appears one clock after the qualifying edge. No combinational input-to-output paths.
- Invariant: LO <= out <= HI at all times.
- Defensive rule: an illegal out value (unreachable) is replaced by HI on the next enabled edge.
- Continuous-mode period = HI-LO+1 enabled cycles (11 for the defaults).

Optional Feature:
WRAP_CNT_EN
- Defined: adds output wrap_cnt[7:0]. It increments on every tc pulse, saturates at 255, resets to 0 on rst and clears to 0 on load.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package mod_count_pkg holds:
  - state encoding constants ST_COUNT=1'b0, ST_HALT=1'b1
  - default bound constants CNT_HI_DEF=15, CNT_LO_DEF=5, shared with the up-counter
- Sub-module mod_count_clamp is combinational. Parameters WIDTH/HI/LO; input v, output clamp(v). Reused by the load path and the defensive rule.

Test Plan:
- Reset behaviour: assert rst mid-count at out=9 -> out=HI=15, tc=0, done=0 immediately, without waiting for a clock edge.
- Continuous count: en=1, oneshot=0 from reset, 12 clocks -> out sequence 14,13,...,5,15,14; tc high exactly in the cycle out=15 after 5.
- One-shot halt: en=1, oneshot=1 from reset -> out reaches 5; tc pulses once; done=1; out stays 5 for 20 further clocks with en=1.
- Load and clamp:
  - load_val=8 -> out=8.
  - load_val=3 -> out=15.
  - load_val from HALT -> done=0 on the next cycle and counting resumes.
- Priority and hold: load=1 with load_val=12 at out=5, en=1 -> out=12, tc=0. Then en=0 for 4 clocks -> out holds 12.
- WRAP_CNT_EN build: 300 continuous wraps -> wrap_cnt=255, saturated. Then load -> wrap_cnt=0.
